// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the multiply/divide unit: operation encodings driven
//   by the EXE stage, FSM state encoding, and small decode helpers.
//   Optional feature macro used by muldiv_unit: FAST_MUL_EN.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    // Operation codes presented on muldiv_unit.op
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states: IDLE -> CALC -> FIX -> IDLE
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-divide step.
//   Ports:
//     rem_in   in  WIDTH+1  partial remainder already shifted left with the next
//                           dividend bit appended in the LSB
//     divisor  in  WIDTH    divisor magnitude
//     rem_out  out WIDTH    partial remainder after the trial subtraction
//     q_bit    out 1        quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // The incoming remainder is always below 2*divisor, so a non-negative
    // difference always fits in WIDTH bits and the MSB acts as the borrow.
    assign diff    = rem_in - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit with HI/LO registers for the MIPS core.
//   Shift-add multiply and restoring divide, one bit per cycle, on a shared
//   2*WIDTH accumulator. Signed ops run on magnitudes; the sign is restored in
//   the FIX state.
//   Optional feature: define FAST_MUL_EN to compute MULT/MULTU with a single
//   WIDTH x WIDTH multiply (IDLE -> FIX). Divide is unaffected.
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     start        in   request valid, accepted only while busy==0
//     op           in   md_op_e operation code
//     a, b         in   rs / rt operands
//     wr_hi, wr_lo in   MTHI / MTLO write strobes (ignored while busy)
//     wdata        in   MTHI / MTLO data
//     hi, lo       out  HI / LO registers
//     busy         out  operation in flight
//     done         out  one-cycle pulse, new hi/lo visible in the same cycle
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e          state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   operand_reg;   // multiplicand or divisor magnitude
    logic               is_div_reg;
    logic               neg_q_reg;     // negate product / quotient
    logic               neg_r_reg;     // negate remainder
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg;

    // ---------------- request decode ----------------
    logic             accept;
    logic             op_div;
    logic             sign_a, sign_b;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign accept = start && !busy_reg;
    assign op_div = is_div_op(op);
    assign sign_a = is_signed_op(op) && a[WIDTH-1];
    assign sign_b = is_signed_op(op) && b[WIDTH-1];
    assign b_zero = (b == '0);
    // INT_MIN negates to itself, which is exactly its magnitude as unsigned.
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0]   div_rem_next;
    logic               div_q_bit;
    logic [2*WIDTH-1:0] div_acc_next;

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                        + {1'b0, (acc_reg[0] ? operand_reg : {WIDTH{1'b0}})};
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: accumulator holds {partial remainder, dividend/quotient bits};
    // quotient bits shift in at the bottom as dividend bits shift out the top.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  ({acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]}),
        .divisor (operand_reg),
        .rem_out (div_rem_next),
        .q_bit   (div_q_bit)
    );
    assign div_acc_next = {div_rem_next, acc_reg[WIDTH-2:0], div_q_bit};

    // ---------------- sign correction ----------------
    logic [2*WIDTH-1:0] fix_result;

    always_comb begin
        fix_result = acc_reg;
        if (is_div_reg) begin
            fix_result[WIDTH-1:0]       = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            fix_result[2*WIDTH-1:WIDTH] = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                                    : acc_reg[2*WIDTH-1:WIDTH];
        end else if (neg_q_reg) begin
            fix_result = -acc_reg;
        end
    end

    // ---------------- FSM next state ----------------
    logic finish;

    always_comb begin
        state_next = state_reg;
        finish     = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (accept) begin
                    if (op_div && b_zero) begin
                        state_next = MD_FIX;
`ifdef FAST_MUL_EN
                    end else if (!op_div) begin
                        state_next = MD_FIX;
`endif
                    end else begin
                        state_next = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                state_next = MD_IDLE;
                finish     = 1'b1;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            acc_reg     <= '0;
            operand_reg <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= finish;
            case (state_reg)
                MD_IDLE: begin
                    if (wr_hi) hi_reg <= wdata;
                    if (wr_lo) lo_reg <= wdata;
                    if (accept) begin
                        busy_reg    <= 1'b1;
                        count_reg   <= '0;
                        is_div_reg  <= op_div;
                        neg_q_reg   <= sign_a ^ sign_b;
                        neg_r_reg   <= sign_a;
                        operand_reg <= op_div ? mag_b : mag_a;
                        if (op_div && b_zero) begin
                            // Preload the divide-by-zero result; FIX passes it through.
                            acc_reg   <= {a, {WIDTH{1'b1}}};
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                        end else if (op_div) begin
                            acc_reg <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
`ifdef FAST_MUL_EN
                            acc_reg <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
                            acc_reg <= {{WIDTH{1'b0}}, mag_b};
`endif
                        end
                    end
                end
                MD_CALC: begin
                    acc_reg   <= is_div_reg ? div_acc_next : mul_acc_next;
                    count_reg <= count_reg + 1'b1;
                end
                MD_FIX: begin
                    hi_reg   <= fix_result[2*WIDTH-1:WIDTH];
                    lo_reg   <= fix_result[WIDTH-1:0];
                    busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
